pll_reset_sequencer: RTL and testbench

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

---
 rtl/pll_reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL areset/lock qualification and downstream reset sequencer
// Retries lock after timeout, qualifies lock stability, then holds o_rst before RUN.
module pll_reset_sequencer #(
   parameter int unsigned AREST_CYCLES        = 4,
   parameter int unsigned LOCK_TIMEOUT_CYCLES = 32,
   parameter int unsigned LOCK_STABLE_CYCLES  = 8,
   parameter int unsigned RST_HOLD_CYCLES     = 16,
   parameter int unsigned MAX_RETRIES         = 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_pll_locked,
   input  logic       i_restart,
   output logic       o_pll_areset,
   output logic       o_rst,
   output logic       o_ready,
   output logic       o_fail,
   output logic [2:0] o_state,
   output logic [3:0] o_retry_cnt,
   output logic [7:0] o_loss_cnt
);

   typedef enum logic [2:0] {
      ST_RESET     = 3'd0,
      ST_WAIT_LOCK = 3'd1,
      ST_STABLE    = 3'd2,
      ST_HOLD      = 3'd3,
      ST_RUN       = 3'd4,
      ST_FAIL      = 3'd5
   } state_t;

   localparam logic [15:0] L_AREST_LAST   = 16'(AREST_CYCLES - 1);
   localparam logic [15:0] L_TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [15:0] L_STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
   localparam logic [15:0] L_HOLD_LAST    = 16'(RST_HOLD_CYCLES - 1);
   localparam logic [3:0]  L_MAX_RETRIES  = 4'(MAX_RETRIES);

   logic        r_sync1;
   logic        r_sync2;
   state_t      r_state;
   state_t      w_next_state;
   logic [15:0] r_cnt;
   logic [3:0]  r_retry_cnt;
   logic [3:0]  w_retry_next;
   logic [7:0]  r_loss_cnt;
   logic [7:0]  w_loss_next;
   logic        w_lock_s;
   logic        w_cnt_run;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   assign w_lock_s = r_sync2;

   always_comb begin
      w_next_state = r_state;
      w_retry_next = r_retry_cnt;
      w_loss_next  = r_loss_cnt;
      case (r_state)
         ST_RESET: begin
            if (r_cnt == L_AREST_LAST) w_next_state = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            if (w_lock_s) begin
               w_next_state = ST_STABLE;
            end else if (r_cnt == L_TIMEOUT_LAST) begin
               if (r_retry_cnt == L_MAX_RETRIES) begin
                  w_next_state = ST_FAIL;
               end else begin
                  w_retry_next = r_retry_cnt + 4'd1;
                  w_next_state = ST_RESET;
               end
            end
         end
         ST_STABLE: begin
            if (!w_lock_s)                   w_next_state = ST_WAIT_LOCK;
            else if (r_cnt == L_STABLE_LAST) w_next_state = ST_HOLD;
         end
         ST_HOLD: begin
            if (!w_lock_s) begin
               w_next_state = ST_RESET;
            end else if (r_cnt == L_HOLD_LAST) begin
               w_next_state = ST_RUN;
               w_retry_next = 4'd0;
            end
         end
         ST_RUN: begin
            if (!w_lock_s) begin
               w_next_state = ST_RESET;
               if (r_loss_cnt != 8'hFF) w_loss_next = r_loss_cnt + 8'd1;
            end
         end
         ST_FAIL: begin
            w_next_state = ST_FAIL;
         end
         default: begin
            w_next_state = ST_RESET;
         end
      endcase
      // Restart wins over everything, including a lock loss seen in the same cycle.
      if (i_restart) begin
         w_next_state = ST_RESET;
         w_retry_next = 4'd0;
         w_loss_next  = r_loss_cnt;
      end
   end

   assign w_cnt_run = (r_state == ST_RESET) || (r_state == ST_WAIT_LOCK) ||
                      (r_state == ST_STABLE) || (r_state == ST_HOLD);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_RESET;
         r_cnt       <= 16'd0;
         r_retry_cnt <= 4'd0;
         r_loss_cnt  <= 8'd0;
      end else begin
         r_state     <= w_next_state;
         r_retry_cnt <= w_retry_next;
         r_loss_cnt  <= w_loss_next;
         if ((w_next_state != r_state) || i_restart) r_cnt <= 16'd0;
         else if (w_cnt_run)                         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign o_state      = r_state;
   assign o_pll_areset = (r_state == ST_RESET) || (r_state == ST_FAIL);
   assign o_rst        = (r_state != ST_RUN);
   assign o_ready      = (r_state == ST_RUN);
   assign o_fail       = (r_state == ST_FAIL);
   assign o_retry_cnt  = r_retry_cnt;
   assign o_loss_cnt   = r_loss_cnt;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - directed bench for pll_reset_sequencer
// A countdown-based phase model is compared every cycle; literal timings pin the model.
module tb_pll_reset_sequencer;

   localparam int AR = 4;
   localparam int TO = 32;
   localparam int ST = 8;
   localparam int HO = 16;
   localparam int MR = 2;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_pll_locked;
   logic       i_restart;
   logic       o_pll_areset;
   logic       o_rst;
   logic       o_ready;
   logic       o_fail;
   logic [2:0] o_state;
   logic [3:0] o_retry_cnt;
   logic [7:0] o_loss_cnt;

   int n_vec = 0;
   int n_err = 0;

   pll_reset_sequencer dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_pll_locked (i_pll_locked),
      .i_restart    (i_restart),
      .o_pll_areset (o_pll_areset),
      .o_rst        (o_rst),
      .o_ready      (o_ready),
      .o_fail       (o_fail),
      .o_state      (o_state),
      .o_retry_cnt  (o_retry_cnt),
      .o_loss_cnt   (o_loss_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Phase model: st is the phase number, left counts cycles still owed in that phase.
   typedef struct {
      int st;
      int left;
      int retry;
      int loss;
      bit s1;
      bit s2;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t mdl_reset();
      mdl_t r;
      r.st = 0; r.left = AR; r.retry = 0; r.loss = 0; r.s1 = 1'b0; r.s2 = 1'b0;
      return r;
   endfunction

   function automatic mdl_t mdl_step(input mdl_t c, input bit lock_in, input bit restart);
      mdl_t n;
      bit   ls;
      n  = c;
      ls = c.s2;
      if (restart) begin
         n.st = 0; n.left = AR; n.retry = 0;
      end else begin
         case (c.st)
            0: begin
               n.left = c.left - 1;
               if (n.left == 0) begin n.st = 1; n.left = TO; end
            end
            1: begin
               if (ls) begin
                  n.st = 2; n.left = ST;
               end else begin
                  n.left = c.left - 1;
                  if (n.left == 0) begin
                     if (c.retry == MR) n.st = 5;
                     else begin n.retry = c.retry + 1; n.st = 0; n.left = AR; end
                  end
               end
            end
            2: begin
               if (!ls) begin n.st = 1; n.left = TO; end
               else begin
                  n.left = c.left - 1;
                  if (n.left == 0) begin n.st = 3; n.left = HO; end
               end
            end
            3: begin
               if (!ls) begin n.st = 0; n.left = AR; end
               else begin
                  n.left = c.left - 1;
                  if (n.left == 0) begin n.st = 4; n.retry = 0; end
               end
            end
            4: begin
               if (!ls) begin
                  n.st = 0; n.left = AR;
                  n.loss = (c.loss < 255) ? c.loss + 1 : 255;
               end
            end
            default: ;
         endcase
      end
      n.s2 = c.s1;
      n.s1 = lock_in;
      return n;
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) m <= mdl_reset();
      else          m <= mdl_step(m, i_pll_locked, i_restart);
   end

   always @(negedge i_clk) begin
      n_vec++;
      if (o_state !== 3'(m.st) || o_pll_areset !== (m.st == 0 || m.st == 5) ||
          o_rst !== (m.st != 4) || o_ready !== (m.st == 4) || o_fail !== (m.st == 5) ||
          o_retry_cnt !== 4'(m.retry) || o_loss_cnt !== 8'(m.loss)) begin
         n_err++;
         $display("FAIL model_cmp t=%0t (dut/exp) state=%0d/%0d areset=%b/%b rst=%b/%b ready=%b/%b fail=%b/%b retry=%0d/%0d loss=%0d/%0d",
                  $time, o_state, m.st, o_pll_areset, (m.st == 0 || m.st == 5), o_rst, (m.st != 4),
                  o_ready, (m.st == 4), o_fail, (m.st == 5), o_retry_cnt, m.retry, o_loss_cnt, m.loss);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic at_drive();
      @(posedge i_clk);
      #2;
   endtask

   task automatic wait_state(input int st, input int budget, input string name);
      int k;
      k = 0;
      while (o_state !== 3'(st) && k < budget) begin
         @(negedge i_clk);
         k++;
      end
      check(name, int'(o_state), st);
   endtask

   task automatic edges_to_state(input int st, input int budget, output int n);
      n = 0;
      do begin
         @(posedge i_clk);
         n++;
         #1;
      end while (o_state !== 3'(st) && n < budget);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"},  int'(o_state), 0);
      check({tag, "_areset"}, int'(o_pll_areset), 1);
      check({tag, "_rst"},    int'(o_rst), 1);
      check({tag, "_ready"},  int'(o_ready), 0);
      check({tag, "_fail"},   int'(o_fail), 0);
      check({tag, "_retry"},  int'(o_retry_cnt), 0);
      check({tag, "_loss"},   int'(o_loss_cnt), 0);
   endtask

   initial begin
      int n, n1, n2, saw_hold, rst_low, pulses, run, bad_len, st107;
      bit prev;
      i_rst_n = 1'b0;
      i_pll_locked = 1'b0;
      i_restart = 1'b0;
      repeat (3) @(negedge i_clk);
      check_reset_values("por");

      at_drive();
      i_rst_n = 1'b1;
      n = 0;
      @(negedge i_clk);
      while (o_state == 3'd0 && n < 100) begin
         n++;
         @(negedge i_clk);
      end
      check("reset_len", n, 4);
      check("after_reset_state", int'(o_state), 1);

      // One timeout first so the glitch can show the retry count is preserved.
      wait_state(0, 100, "first_timeout");
      check("retry_after_timeout", int'(o_retry_cnt), 1);
      wait_state(1, 20, "rewait");

      at_drive();
      i_pll_locked = 1'b1;
      wait_state(2, 20, "glitch_stable");
      repeat (3) at_drive();
      i_pll_locked = 1'b0;
      saw_hold = 0;
      rst_low = 0;
      n = 0;
      while (o_state !== 3'd1 && n < 20) begin
         @(negedge i_clk);
         if (o_state == 3'd3) saw_hold = 1;
         if (o_rst !== 1'b1) rst_low = 1;
         n++;
      end
      check("glitch_to_wait", int'(o_state), 1);
      check("glitch_no_hold", saw_hold, 0);
      check("glitch_rst_high", rst_low, 0);
      check("glitch_retry", int'(o_retry_cnt), 1);

      at_drive();
      i_pll_locked = 1'b1;
      edges_to_state(2, 50, n1);
      check("lock_to_stable_edges", n1 - 1, 2);
      edges_to_state(4, 50, n2);
      check("lock_to_run_edges", n1 + n2 - 1, 26);
      check("run_ready", int'(o_ready), 1);
      check("run_rst", int'(o_rst), 0);
      check("run_retry_clr", int'(o_retry_cnt), 0);

      at_drive();
      i_pll_locked = 1'b0;
      edges_to_state(0, 10, n1);
      check("loss_to_reset_edges", n1 - 1, 2);
      check("loss_rst", int'(o_rst), 1);
      check("loss_cnt1", int'(o_loss_cnt), 1);
      #1;
      i_pll_locked = 1'b1;
      wait_state(4, 200, "reseq_run");

      at_drive();
      i_restart = 1'b1;
      @(posedge i_clk);
      #1;
      check("rs_run_state", int'(o_state), 0);
      check("rs_run_retry", int'(o_retry_cnt), 0);
      check("rs_run_fail", int'(o_fail), 0);
      check("rs_run_loss", int'(o_loss_cnt), 1);
      #1;
      i_restart = 1'b0;
      wait_state(4, 200, "rs_run_back");

      for (int i = 0; i < 255; i++) begin
         at_drive();
         i_pll_locked = 1'b0;
         wait_state(0, 20, "sat_drop");
         at_drive();
         i_pll_locked = 1'b1;
         wait_state(4, 200, "sat_run");
      end
      check("loss_saturated", int'(o_loss_cnt), 255);

      at_drive();
      i_pll_locked = 1'b0;
      wait_state(0, 20, "hold_drop");
      at_drive();
      i_pll_locked = 1'b1;
      wait_state(3, 100, "reach_hold");
      #3;
      i_rst_n = 1'b0;
      #1;
      check_reset_values("async");

      i_pll_locked = 1'b0;
      repeat (2) @(negedge i_clk);
      at_drive();
      i_rst_n = 1'b1;
      pulses = 0; run = 0; bad_len = 0; prev = 1'b0; st107 = -1;
      for (int j = 0; j < 108; j++) begin
         @(negedge i_clk);
         if (o_pll_areset === 1'b1) begin
            if (!prev) pulses++;
            run = prev ? run + 1 : 1;
         end else if (prev && run != AR) begin
            bad_len++;
         end
         prev = (o_pll_areset === 1'b1);
         if (j == 107) st107 = int'(o_state);
      end
      check("nolock_pulses", pulses, 3);
      check("nolock_pulse_len", bad_len, 0);
      check("nolock_state107", st107, 1);
      @(negedge i_clk);
      check("nolock_fail_state", int'(o_state), 5);
      check("nolock_fail_flag", int'(o_fail), 1);
      check("nolock_areset", int'(o_pll_areset), 1);
      check("nolock_retry", int'(o_retry_cnt), 2);
      repeat (10) @(negedge i_clk);
      check("fail_sticky", int'(o_state), 5);

      at_drive();
      i_restart = 1'b1;
      @(posedge i_clk);
      #1;
      check("rs_fail_state", int'(o_state), 0);
      check("rs_fail_retry", int'(o_retry_cnt), 0);
      check("rs_fail_flag", int'(o_fail), 0);
      check("rs_fail_loss", int'(o_loss_cnt), 0);
      #1;
      i_restart = 1'b0;
      i_pll_locked = 1'b1;
      wait_state(4, 200, "post_fail_run");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
